mmu_task_ctl: RTL

- Synchronous, parametrised successor to the SBC09 task MMU.
- Holds its own task map RAM internally, so no external MMU SRAM is needed.
- Translates the 6809 logical page to a physical page with a per-page read-only flag, handles automatic system/user task switching with a programmable RTI delay, and raises a write-protect fault.
- Sits between the CPU bus and the chip-select decode, in the fast CLK domain, sampling the CPU E strobe.

---
 rtl/mmu_task_ctl_if.sv | 53 +++++
 rtl/mmu_task_ctl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_task_ctl_if.sv
// mmu_task_ctl_if
// -----------------------------------------------------------------------------
// CPU-bus / MMU-output bundle for mmu_task_ctl.
//
// Timing: the CPU-side fields (ADDR, RnW, BA, BS, DATA_in) are valid while E
// is high. They must stay stable through the first CLK edge at which E is
// seen low again (the E falling edge). Every MMU state change commits at that
// edge. The outputs are combinational from the current bus fields and the
// committed state.
//
// Parameter:
//   PHYS_BITS  width of the translated physical page number
//
// master modport (CPU side):
//   out: E, ADDR[15:0], RnW, BA, BS, DATA_in[7:0]
//   in : DATA_out[7:0], DATA_oe, PHYS_PAGE, PAGE_RO, MEM_nWR, IO_SEL, REG_SEL,
//        INTMASK, USER, FAULT_IRQ
// slave modport (MMU side): the same signals with directions reversed.
interface mmu_task_ctl_if #(
  parameter int PHYS_BITS = 7
);
  // CPU side
  logic                 E;
  logic [15:0]          ADDR;
  logic                 RnW;
  logic                 BA;
  logic                 BS;
  logic [7:0]           DATA_in;

  // MMU side
  logic [7:0]           DATA_out;
  logic                 DATA_oe;
  logic [PHYS_BITS-1:0] PHYS_PAGE;
  logic                 PAGE_RO;
  logic                 MEM_nWR;
  logic                 IO_SEL;
  logic                 REG_SEL;
  logic                 INTMASK;
  logic                 USER;
  logic                 FAULT_IRQ;

  modport master (
    output E, ADDR, RnW, BA, BS, DATA_in,
    input  DATA_out, DATA_oe, PHYS_PAGE, PAGE_RO, MEM_nWR, IO_SEL, REG_SEL,
           INTMASK, USER, FAULT_IRQ
  );

  modport slave (
    input  E, ADDR, RnW, BA, BS, DATA_in,
    output DATA_out, DATA_oe, PHYS_PAGE, PAGE_RO, MEM_nWR, IO_SEL, REG_SEL,
           INTMASK, USER, FAULT_IRQ
  );
endinterface

// File: rtl/mmu_task_ctl.sv
// mmu_task_ctl
// -----------------------------------------------------------------------------
// Synchronous task MMU for a 6809 system. It is clocked by the fast CLK and
// samples the CPU E strobe.
//
// The block holds a task map RAM of 2^(TASK_BITS+PAGE_BITS) entries. It
// translates the logical page (top PAGE_BITS of ADDR) of the current task to a
// physical page with a read-only flag.
// - It switches automatically between system mode (task 0) and user mode
//   (task_key).
// - An RTI trigger read enters user mode after SWITCH_DELAY CPU cycles.
// - A vector fetch returns to system mode and holds INTMASK.
// - A user write to a read-only page has its memory strobe suppressed and
//   raises a fault.
//
// Optional feature macro: MMU_FAULT_CAPTURE_EN
//   defined   : fault address and task are captured on the first fault. They
//               are readable at offsets 4..6. FAULT_IRQ reports the pending
//               flag, and a read of offset 4 clears it.
//   undefined : offsets 4..6 read 0 and FAULT_IRQ is tied low. Write
//               suppression still applies.
//
// Ports:
//   CLK         system clock (>= 4x E)
//   RESET       synchronous, active-high reset
//   bus         mmu_task_ctl_if.slave: E, ADDR, RnW, BA, BS, DATA_in in;
//               DATA_out, DATA_oe, PHYS_PAGE, PAGE_RO, MEM_nWR, IO_SEL,
//               REG_SEL, INTMASK, USER, FAULT_IRQ out
//   task_state  current task FSM state (0 SYS, 1 ARM, 2 USER)
//
// Register window at REG_BASE (offset = ADDR[4:0]):
//   0 ctrl {4'b0, !USER (ro), protect, fine, enmmu}
//   1 access_key
//   2 task_key
//   3 RTI trigger (reads 8'h3B)
//   4 fault status {pending, 2'b0, task}
//   5 fault address high
//   6 fault address low
//   16..31 map window
module mmu_task_ctl #(
  parameter int          TASK_BITS    = 5,
  parameter int          PAGE_BITS    = 3,
  parameter int          PHYS_BITS    = 7,
  parameter int          MASK_CYCLES  = 3,
  parameter int          SWITCH_DELAY = 1,
  parameter logic [15:0] REG_BASE     = 16'hFE20,
  parameter logic [15:0] IO_MIN       = 16'hFC00,
  parameter logic [15:0] IO_MAX       = 16'hFEFF
) (
  input  logic             CLK,
  input  logic             RESET,
  mmu_task_ctl_if.slave    bus,
  output logic [1:0]       task_state
);

  localparam int          MAP_AW    = TASK_BITS + PAGE_BITS;
  localparam int          MAP_DEPTH = 1 << MAP_AW;
  localparam int          MW        = (MASK_CYCLES < 1) ? 1 : $clog2(MASK_CYCLES + 1);
  localparam logic [15:0] REG_TOP   = REG_BASE + 16'd31;

  typedef enum logic [1:0] {
    ST_SYS  = 2'd0,
    ST_ARM  = 2'd1,
    ST_USER = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 e_d;
  logic                 enmmu;
  logic                 fine;
  logic                 protect;
  logic [TASK_BITS-1:0] access_key;
  logic [TASK_BITS-1:0] task_key;
  state_t               state;
  state_t               state_nx;
  logic [2:0]           cnt;
  logic [2:0]           cnt_nx;
  logic [MW-1:0]        mask_cnt;
  logic [PHYS_BITS:0]   map_ram [MAP_DEPTH];

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic                 e_fall;
  logic                 user_mode;
  logic                 access_vector;
  logic                 hw_en;
  logic                 in_io;
  logic                 in_reg;
  logic                 reg_sel;
  logic [4:0]           reg_off;
  logic                 reg_wr;
  logic                 reg_rd;
  logic                 rti_rd;
  logic                 map_wr;

  assign e_fall        = e_d & ~bus.E;
  assign user_mode     = (state == ST_USER);
  assign access_vector = ~bus.BA & bus.BS & bus.RnW;

  // In protected user mode the I/O hole and the register window are hidden.
  assign hw_en   = ~enmmu | ~user_mode | ~protect;
  assign in_io   = (bus.ADDR >= IO_MIN) && (bus.ADDR <= IO_MAX);
  assign in_reg  = (bus.ADDR >= REG_BASE) && (bus.ADDR <= REG_TOP);
  assign reg_sel = hw_en & in_reg;
  assign reg_off = bus.ADDR[4:0];

  assign reg_wr  = e_fall & reg_sel & ~bus.RnW;
  assign reg_rd  = e_fall & reg_sel & bus.RnW;
  assign rti_rd  = reg_rd & (reg_off == 5'd3);
  assign map_wr  = reg_wr & reg_off[4];

  // ---------------------------------------------------------------------------
  // Translation
  // ---------------------------------------------------------------------------
  logic [TASK_BITS-1:0] xlate_task;
  logic [PAGE_BITS-1:0] log_page;
  logic [PAGE_BITS-1:0] xlate_page;
  logic [PHYS_BITS:0]   map_rd;
  logic [PHYS_BITS:0]   map_rb;
  logic [PHYS_BITS-1:0] pass_phys;
  logic                 passthrough;
  logic                 page_ro;
  logic                 write_prot;

  // A vector fetch always translates through task 0, even while USER is still
  // set during the fetch cycle itself.
  assign xlate_task = (user_mode & ~access_vector) ? task_key : '0;
  assign log_page   = bus.ADDR[15 -: PAGE_BITS];
  // Coarse mode pairs adjacent logical pages onto one map entry.
  assign xlate_page = fine ? log_page : {log_page[PAGE_BITS-1:1], 1'b0};
  assign map_rd     = map_ram[{xlate_task, xlate_page}];
  assign map_rb     = map_ram[{access_key, bus.ADDR[PAGE_BITS-1:0]}];

  assign pass_phys   = PHYS_BITS'(log_page);
  assign passthrough = ~enmmu | in_io;
  assign page_ro     = ~passthrough & map_rd[PHYS_BITS];

  assign write_prot = user_mode & enmmu & protect & page_ro & ~bus.RnW;

  assign bus.PHYS_PAGE = passthrough ? pass_phys : map_rd[PHYS_BITS-1:0];
  assign bus.PAGE_RO   = page_ro;
  assign bus.MEM_nWR   = RESET | write_prot | ~(bus.E & ~bus.RnW);
  assign bus.IO_SEL    = hw_en & in_io;
  assign bus.REG_SEL   = reg_sel;
  assign bus.INTMASK   = ~RESET & (access_vector | (mask_cnt != '0));
  assign bus.USER      = user_mode;
  assign task_state    = state;

  // ---------------------------------------------------------------------------
  // Fault capture
  // ---------------------------------------------------------------------------
`ifdef MMU_FAULT_CAPTURE_EN
  logic                 fault_pending;
  logic [15:0]          fault_addr;
  logic [TASK_BITS-1:0] fault_task;
  logic                 fault_set;
  logic                 stat_rd;

  assign fault_set = e_fall & write_prot;
  assign stat_rd   = reg_rd & (reg_off == 5'd4);

  // A new fault wins over a status read in the same cycle. The capture
  // registers take the new fault once the old one is being read out.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fault_pending <= 1'b0;
      fault_addr    <= '0;
      fault_task    <= '0;
    end else begin
      if (fault_set) begin
        fault_pending <= 1'b1;
      end else if (stat_rd) begin
        fault_pending <= 1'b0;
      end
      if (fault_set & (~fault_pending | stat_rd)) begin
        fault_addr <= bus.ADDR;
        fault_task <= xlate_task;
      end
    end
  end

  assign bus.FAULT_IRQ = fault_pending;
`else
  assign bus.FAULT_IRQ = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Register readback
  // ---------------------------------------------------------------------------
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    if (reg_off[4]) begin
      rd_data = {map_rb[PHYS_BITS], 7'(map_rb[PHYS_BITS-1:0])};
    end else begin
      case (reg_off[3:0])
        4'd0:    rd_data = {4'b0000, ~user_mode, protect, fine, enmmu};
        4'd1:    rd_data = 8'(access_key);
        4'd2:    rd_data = 8'(task_key);
        4'd3:    rd_data = 8'h3B;
`ifdef MMU_FAULT_CAPTURE_EN
        4'd4:    rd_data = {fault_pending, 2'b00, 5'(fault_task)};
        4'd5:    rd_data = fault_addr[15:8];
        4'd6:    rd_data = fault_addr[7:0];
`endif
        default: rd_data = 8'h00;
      endcase
    end
  end

  assign bus.DATA_out = rd_data;
  assign bus.DATA_oe  = bus.E & bus.RnW & reg_sel;

  // ---------------------------------------------------------------------------
  // Task FSM
  // ---------------------------------------------------------------------------
  // cnt counts the remaining E falls in ARM minus one, so the switch lands
  // exactly SWITCH_DELAY CPU cycles after the trigger read.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (e_fall) begin
      if (access_vector) begin
        state_nx = ST_SYS;
        cnt_nx   = 3'd0;
      end else begin
        case (state)
          ST_SYS: begin
            if (rti_rd) begin
              if (SWITCH_DELAY == 0) begin
                state_nx = ST_USER;
              end else begin
                state_nx = ST_ARM;
                cnt_nx   = 3'(SWITCH_DELAY - 1);
              end
            end
          end
          ST_ARM: begin
            if (cnt == 3'd0) begin
              state_nx = ST_USER;
            end else begin
              cnt_nx = cnt - 3'd1;
            end
          end
          ST_USER: begin
            state_nx = ST_USER;
          end
          default: begin
            state_nx = ST_SYS;
            cnt_nx   = 3'd0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      e_d        <= 1'b0;
      enmmu      <= 1'b0;
      fine       <= 1'b0;
      protect    <= 1'b0;
      access_key <= '0;
      task_key   <= '0;
      state      <= ST_SYS;
      cnt        <= 3'd0;
      mask_cnt   <= '0;
    end else begin
      e_d   <= bus.E;
      state <= state_nx;
      cnt   <= cnt_nx;
      if (e_fall) begin
        if (access_vector) begin
          mask_cnt <= MW'(MASK_CYCLES);
        end else if (mask_cnt != '0) begin
          mask_cnt <= mask_cnt - MW'(1);
        end
        if (reg_wr && !reg_off[4]) begin
          case (reg_off[3:0])
            4'd0: begin
              protect <= bus.DATA_in[2];
              fine    <= bus.DATA_in[1];
              enmmu   <= bus.DATA_in[0];
            end
            4'd1:    access_key <= bus.DATA_in[TASK_BITS-1:0];
            4'd2:    task_key   <= bus.DATA_in[TASK_BITS-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // The map RAM is deliberately not reset; software loads it before enabling.
  always_ff @(posedge CLK) begin
    if (map_wr) begin
      map_ram[{access_key, bus.ADDR[PAGE_BITS-1:0]}] <=
        {bus.DATA_in[7], bus.DATA_in[PHYS_BITS-1:0]};
    end
  end

endmodule
